// File: rtl/sram_cnt_pkg.sv
// Shared widths, request entry layout and header-hash fold for the SRAM counter request generator.
package sram_cnt_pkg;

  localparam int unsigned TDATA_WIDTH     = 32;
  localparam int unsigned TDATA_BITS      = 8 * TDATA_WIDTH;
  localparam int unsigned TUSER_WIDTH     = 128;
  localparam int unsigned QUEUE_ID_WIDTH  = 2;
  localparam int unsigned QID_LSB         = 16;
  localparam int unsigned MEM_ADDR_WIDTH  = 19;
  localparam int unsigned HASH_LSB        = 96;
  localparam int unsigned HASH_WIDTH      = 96;
  localparam int unsigned LEN_WIDTH       = 16;
  localparam int unsigned REQ_FIFO_DEPTH  = 4;
  localparam int unsigned REQ_FIFO_BITS   = $clog2(REQ_FIFO_DEPTH);
  localparam int unsigned HAZARD_CYCLES   = 8;
  localparam int unsigned ISSUE_GAP       = 2;
  localparam int unsigned GAP_W           = $clog2(ISSUE_GAP + 1);
  localparam int unsigned REQ_DATA_WIDTH  = TDATA_BITS + 9;
  localparam int unsigned HASH_CHUNKS     = (HASH_WIDTH + MEM_ADDR_WIDTH - 1) / MEM_ADDR_WIDTH;
  localparam int unsigned HASH_PAD_WIDTH  = HASH_CHUNKS * MEM_ADDR_WIDTH;

  typedef enum logic {ST_HDR, ST_BODY} parse_state_t;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [QUEUE_ID_WIDTH-1:0] qid;
    logic [LEN_WIDTH-1:0]      len;
  } req_entry_t;

  // XOR-fold the header window into one SRAM word address; top chunk is zero-padded.
  function automatic logic [MEM_ADDR_WIDTH-1:0] addr_fold(input logic [HASH_WIDTH-1:0] win);
    logic [HASH_PAD_WIDTH-1:0] padded;
    logic [MEM_ADDR_WIDTH-1:0] acc;
    padded = HASH_PAD_WIDTH'(win);
    acc    = '0;
    for (int unsigned i = 0; i < HASH_CHUNKS; i++) begin
      acc = acc ^ padded[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/sram_cnt_req_gen_if.sv
// Request channel into the RMW controller write port, with its back-pressure signals.
interface sram_cnt_req_gen_if;
  import sram_cnt_pkg::*;

  logic [MEM_ADDR_WIDTH-1:0] req_addr;
  logic [QUEUE_ID_WIDTH-1:0] req_queue_id;
  logic [REQ_DATA_WIDTH-1:0] req_data;
  logic                      req_valid;
  logic                      wr_full;
  logic                      wr_busy;

  modport master (output req_addr, req_queue_id, req_data, req_valid,
                  input  wr_full, wr_busy);
  modport slave  (input  req_addr, req_queue_id, req_data, req_valid,
                  output wr_full, wr_busy);
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO; head word is readable whenever empty is low.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 37,
  parameter int unsigned MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CW-1:0]             count;
  logic                      do_wr;
  logic                      do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_cnt_req_gen.sv
// Hashes each packet header into an SRAM address and issues one counter-update request per packet.
module sram_cnt_req_gen
  import sram_cnt_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TDATA_BITS-1:0]  s_axis_tdata,
  input  logic [TDATA_WIDTH-1:0] s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  sram_cnt_req_gen_if.master     ctrl,
  output logic [31:0]            stat_drop_cnt,
  output logic [31:0]            stat_stall_cnt
);

  localparam int unsigned ENTRY_W = $bits(req_entry_t);

  parse_state_t              state, state_nxt;
  req_entry_t                push_entry;
  req_entry_t                head;
  logic [ENTRY_W-1:0]        fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      hdr_beat;
  logic                      push;
  logic                      drop;
  logic                      hazard;
  logic                      issue;
  logic                      stall;
  logic [GAP_W-1:0]          gap_cnt;
  logic [HAZARD_CYCLES-1:0]  haz_valid;
  logic [MEM_ADDR_WIDTH-1:0] haz_addr [HAZARD_CYCLES];
  logic                      unused_ok;

  assign s_axis_tready = 1'b1;
  assign unused_ok     = ^{s_axis_tkeep, s_axis_tuser, s_axis_tdata};

  assign push_entry.addr = addr_fold(s_axis_tdata[HASH_LSB +: HASH_WIDTH]);
  assign push_entry.qid  = s_axis_tuser[QID_LSB +: QUEUE_ID_WIDTH];
  assign push_entry.len  = s_axis_tuser[LEN_WIDTH-1:0];
  assign head            = fifo_dout;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_HDR;
    else       state <= state_nxt;
  end

  // Packet parser plus push/issue/hazard decisions for the current cycle.
  always_comb begin
    state_nxt = state;
    hdr_beat  = 1'b0;
    hazard    = 1'b0;
    case (state)
      ST_HDR: begin
        if (s_axis_tvalid) begin
          hdr_beat = 1'b1;
          if (!s_axis_tlast) state_nxt = ST_BODY;
        end
      end
      ST_BODY: begin
        if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_HDR;
      end
    endcase
    for (int unsigned i = 0; i < HAZARD_CYCLES; i++) begin
      if (haz_valid[i] && (haz_addr[i] == head.addr)) hazard = 1'b1;
    end
    push  = hdr_beat & ~fifo_full;
    drop  = hdr_beat & fifo_full;
    stall = ~fifo_empty & hazard;
    issue = ~fifo_empty & ~ctrl.wr_full & ~ctrl.wr_busy & (gap_cnt == '0) & ~hazard;
  end

  fallthrough_small_fifo #(
    .WIDTH          (ENTRY_W),
    .MAX_DEPTH_BITS (REQ_FIFO_BITS)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (push_entry),
    .wr_en (push),
    .rd_en (issue),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Registered request outputs, issue spacing, in-flight address history and stats.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl.req_valid    <= 1'b0;
      ctrl.req_addr     <= '0;
      ctrl.req_queue_id <= '0;
      ctrl.req_data     <= '0;
      gap_cnt           <= '0;
      haz_valid         <= '0;
      for (int unsigned i = 0; i < HAZARD_CYCLES; i++) haz_addr[i] <= '0;
      stat_drop_cnt     <= '0;
      stat_stall_cnt    <= '0;
    end else begin
      ctrl.req_valid    <= issue;
      ctrl.req_addr     <= issue ? head.addr : '0;
      ctrl.req_queue_id <= issue ? head.qid  : '0;
      ctrl.req_data     <= issue ? REQ_DATA_WIDTH'(head.len) : '0;
      if (issue)                gap_cnt <= GAP_W'(ISSUE_GAP - 1);
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GAP_W'(1);
      haz_valid   <= {haz_valid[HAZARD_CYCLES-2:0], issue};
      haz_addr[0] <= issue ? head.addr : '0;
      for (int unsigned i = 1; i < HAZARD_CYCLES; i++) haz_addr[i] <= haz_addr[i-1];
      if (drop && (stat_drop_cnt != 32'hFFFF_FFFF))   stat_drop_cnt  <= stat_drop_cnt + 32'd1;
      if (stall && (stat_stall_cnt != 32'hFFFF_FFFF)) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sram_cnt_req_gen.sv
// Directed scoreboard bench for sram_cnt_req_gen.
module tb_sram_cnt_req_gen;
  import sram_cnt_pkg::*;

  localparam int unsigned CW = 300;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [QUEUE_ID_WIDTH-1:0] qid;
    logic [REQ_DATA_WIDTH-1:0] data;
    logic [31:0]               cyc;
    logic                      busy;
  } obs_t;

  logic                   clk;
  logic                   reset;
  logic [TDATA_BITS-1:0]  tdata;
  logic [TDATA_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;
  logic [31:0]            drop_cnt;
  logic [31:0]            stall_cnt;

  sram_cnt_req_gen_if ctrl();

  sram_cnt_req_gen dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tuser   (tuser),
    .s_axis_tvalid  (tvalid),
    .s_axis_tlast   (tlast),
    .s_axis_tready  (tready),
    .ctrl           (ctrl.master),
    .stat_drop_cnt  (drop_cnt),
    .stat_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic toggle_busy = 1'b0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  function automatic logic [MEM_ADDR_WIDTH-1:0] model_fold(input logic [HASH_WIDTH-1:0] w);
    logic [MEM_ADDR_WIDTH-1:0] a;
    a = '0;
    for (int i = 0; i < int'(HASH_WIDTH); i++) a[i % int'(MEM_ADDR_WIDTH)] ^= w[i];
    return a;
  endfunction

  task automatic check(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock; samples outputs 1 time unit after the edge and logs any request seen.
  task automatic tick();
    logic b;
    obs_t o;
    b = ctrl.wr_busy;
    @(posedge clk);
    #1;
    cyc++;
    if (ctrl.req_valid === 1'b1) begin
      o.addr = ctrl.req_addr;
      o.qid  = ctrl.req_queue_id;
      o.data = ctrl.req_data;
      o.cyc  = 32'(cyc);
      o.busy = b;
      obs_q.push_back(o);
    end
    if (toggle_busy) ctrl.wr_busy = ~ctrl.wr_busy;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_beat(input logic [HASH_WIDTH-1:0] win, input logic [1:0] qid,
                            input logic [15:0] len, input logic last, input logic is_hdr);
    obs_t e;
    for (int i = 0; i < 8; i++) tdata[i*32 +: 32] = $urandom();
    for (int i = 0; i < 4; i++) tuser[i*32 +: 32] = $urandom();
    tdata[HASH_LSB +: HASH_WIDTH]    = win;
    tuser[15:0]                      = len;
    tuser[QID_LSB +: QUEUE_ID_WIDTH] = qid;
    tkeep  = $urandom();
    tvalid = 1'b1;
    tlast  = last;
    if (is_hdr) begin
      e.addr = model_fold(win);
      e.qid  = qid;
      e.data = REQ_DATA_WIDTH'(len);
      e.cyc  = '0;
      e.busy = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int b;
    b = 0;
    tvalid = 1'b0;
    while (obs_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    check({tag, "_arrived"}, CW'(obs_q.size() >= n), CW'(1));
  endtask

  task automatic compare_sb(input string tag);
    obs_t o, e;
    check({tag, "_count"}, CW'(obs_q.size()), CW'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_addr"}, CW'(o.addr), CW'(e.addr));
      check({tag, "_qid"},  CW'(o.qid),  CW'(e.qid));
      check({tag, "_data"}, CW'(o.data), CW'(e.data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] base;
    reset = 1'b1;
    tdata = '0; tkeep = '0; tuser = '0; tvalid = 1'b0; tlast = 1'b0;
    ctrl.wr_full = 1'b0;
    ctrl.wr_busy = 1'b0;
    repeat (3) tick();
    check("rst_valid",  CW'(ctrl.req_valid), CW'(0));
    check("rst_addr",   CW'(ctrl.req_addr),  CW'(0));
    check("rst_data",   CW'(ctrl.req_data),  CW'(0));
    check("rst_tready", CW'(tready),         CW'(1));
    check("rst_drop",   CW'(drop_cnt),       CW'(0));
    check("rst_stall",  CW'(stall_cnt),      CW'(0));
    reset = 1'b0;
    idle(2);

    // 1: single-beat packet, minimum latency of two cycles
    drive_beat(96'h123, 2'd1, 16'd64, 1'b1, 1'b1);
    tick();
    tvalid = 1'b0;
    check("t1_lat1", CW'(ctrl.req_valid), CW'(0));
    tick();
    check("t1_lat2", CW'(ctrl.req_valid), CW'(1));
    check("t1_fold", CW'(ctrl.req_addr),  CW'(19'h00123));
    compare_sb("t1");
    idle(12);

    // 2: same address back-to-back is held off by the in-flight window
    base = stall_cnt;
    drive_beat(96'hABCDE_12345, 2'd2, 16'd100, 1'b1, 1'b1); tick();
    drive_beat(96'hABCDE_12345, 2'd2, 16'd101, 1'b1, 1'b1); tick();
    run_until("t2", 2, 60);
    if (obs_q.size() >= 2)
      check("t2_spacing", CW'((obs_q[1].cyc - obs_q[0].cyc) >= 32'(HAZARD_CYCLES + 1)), CW'(1));
    check("t2_stall", CW'(stall_cnt > base), CW'(1));
    compare_sb("t2");
    idle(12);

    // 3: distinct addresses stream out every ISSUE_GAP cycles in order
    drive_beat({96{1'b1}},                        2'd0, 16'd1,  1'b1, 1'b1); tick();
    drive_beat(96'h8000_0000_0000_0000_0000_0001, 2'd1, 16'd2,  1'b1, 1'b1); tick();
    drive_beat(96'h0ABC,                          2'd2, 16'd3,  1'b1, 1'b1); tick();
    drive_beat(96'h7_FFFF,                        2'd3, 16'd4,  1'b1, 1'b1); tick();
    run_until("t3", 4, 40);
    if (obs_q.size() >= 4)
      for (int i = 1; i < 4; i++)
        check("t3_gap", CW'(obs_q[i].cyc - obs_q[i-1].cyc), CW'(ISSUE_GAP));
    compare_sb("t3");
    idle(12);

    // 4: controller full, six headers overflow a four-entry queue
    base = drop_cnt;
    ctrl.wr_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_beat(96'(32'h5000 + i), 2'(i), 16'(200 + i), 1'b1, i < 4);
      tick();
    end
    idle(14);
    check("t4_held", CW'(obs_q.size()), CW'(0));
    check("t4_drop", CW'(drop_cnt - base), CW'(2));
    ctrl.wr_full = 1'b0;
    run_until("t4", 4, 40);
    idle(4);
    compare_sb("t4");
    idle(12);

    // 5: busy toggling each cycle, issues only where busy was low
    toggle_busy = 1'b1;
    drive_beat(96'h111, 2'd1, 16'd11, 1'b1, 1'b1); tick();
    drive_beat(96'h222, 2'd2, 16'd22, 1'b1, 1'b1); tick();
    drive_beat(96'h333, 2'd3, 16'd33, 1'b1, 1'b1); tick();
    run_until("t5", 3, 60);
    toggle_busy  = 1'b0;
    ctrl.wr_busy = 1'b0;
    for (int i = 0; i < obs_q.size(); i++)
      check("t5_busy", CW'(obs_q[i].busy), CW'(0));
    idle(4);
    compare_sb("t5");
    idle(12);

    // 6: reset in the body of a four-beat packet
    ctrl.wr_busy = 1'b1;
    drive_beat(96'h444, 2'd0, 16'd44, 1'b0, 1'b1); tick();
    drive_beat(96'h555, 2'd0, 16'd55, 1'b0, 1'b0); tick();
    tvalid = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    check("t6_valid", CW'(ctrl.req_valid), CW'(0));
    check("t6_drop",  CW'(drop_cnt),       CW'(0));
    check("t6_stall", CW'(stall_cnt),      CW'(0));
    ctrl.wr_busy = 1'b0;
    idle(12);
    check("t6_fifo_empty", CW'(obs_q.size()), CW'(0));
    drive_beat(96'h666, 2'd3, 16'd66, 1'b0, 1'b1); tick();
    drive_beat(96'h777, 2'd1, 16'd77, 1'b1, 1'b0); tick();
    run_until("t6", 1, 20);
    idle(12);
    compare_sb("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
